// File: rtl/q_pkg.sv
// Shared constants and width rule for the Q-learning update pipeline.
package q_pkg;

    localparam int unsigned GAMMA_MASK_W  = 4;
    localparam int unsigned ALPHA_SHIFT_W = 3;

    // gamma = 0.5 + 0.25 + 0.125 = 0.875
    localparam logic [GAMMA_MASK_W-1:0]  DEFAULT_GAMMA_MASK  = 4'b0111;
    // alpha = 0.5
    localparam logic [ALPHA_SHIFT_W-1:0] DEFAULT_ALPHA_SHIFT = 3'd1;

    // Internal datapath width: headroom for reward + g - old_q without overflow.
    function automatic int unsigned q_int_width(input int unsigned w);
        return w + 3;
    endfunction

endpackage

// File: rtl/q_update_pipe_if.sv
// Operand/result handshake bundle for q_update_pipe; slave is the unit, master drives it.
interface q_update_pipe_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 16
) ();
    import q_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [W-1:0]      old_q;
    logic signed [W-1:0]      max_q;
    logic signed [W-1:0]      reward;
    logic [TAG_W-1:0]         tag_in;
    logic [GAMMA_MASK_W-1:0]  gamma_mask;
    logic [ALPHA_SHIFT_W-1:0] alpha_shift;

    logic                     out_valid;
    logic                     out_ready;
    logic [W-1:0]             new_q;
    logic [TAG_W-1:0]         tag_out;
    logic                     out_sat;
    logic [CNT_W-1:0]         update_cnt;

    modport slave (
        input  in_valid, old_q, max_q, reward, tag_in, gamma_mask, alpha_shift, out_ready,
        output in_ready, out_valid, new_q, tag_out, out_sat, update_cnt
    );

    modport master (
        output in_valid, old_q, max_q, reward, tag_in, gamma_mask, alpha_shift, out_ready,
        input  in_ready, out_valid, new_q, tag_out, out_sat, update_cnt
    );

endinterface

// File: rtl/q_gamma_sum.sv
// Combinational gamma*max_q: bit k of gamma_mask adds max_q >>> (k+1), sign-extended first.
module q_gamma_sum
    import q_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic signed [W-1:0]                max_q,
    input  logic [GAMMA_MASK_W-1:0]            gamma_mask,
    output logic signed [q_int_width(W)-1:0]   g
);

    localparam int unsigned IW = q_int_width(W);

    logic signed [IW-1:0] max_ext;

    assign max_ext = {{(IW - W){max_q[W-1]}}, max_q};

    always_comb begin
        g = '0;
        for (int k = 0; k < GAMMA_MASK_W; k++) begin
            if (gamma_mask[k]) begin
                g = g + (max_ext >>> (k + 1));
            end
        end
    end

endmodule

// File: rtl/q_update_pipe.sv
// Three-stage shift-and-add Q update: new_q = old_q + alpha*(reward + gamma*max_q - old_q).
// Define QUPD_SATURATE_EN to clamp the result to W bits (out_sat flags a clamp); default wraps.
module q_update_pipe
    import q_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input logic            clk,
    input logic            rst,
    q_update_pipe_if.slave bus
);

    localparam int unsigned IW  = q_int_width(W);
    localparam int unsigned EXT = IW - W;

    localparam logic signed [IW-1:0] QMax = {{(EXT + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [IW-1:0] QMin = {{(EXT + 1){1'b1}}, {(W - 1){1'b0}}};

    // Fixed-point position does not affect the datapath.
    logic [31:0] unused_frac;
    assign unused_frac = 32'(FRAC);

    logic en;

    logic signed [IW-1:0] g;
    logic signed [IW-1:0] old_ext;
    logic signed [IW-1:0] reward_ext;
    logic signed [IW-1:0] d;

    logic                     s1_valid_q;
    logic signed [IW-1:0]     s1_d_q;
    logic signed [IW-1:0]     s1_old_q;
    logic [ALPHA_SHIFT_W-1:0] s1_shift_q;
    logic [TAG_W-1:0]         s1_tag_q;

    logic                 s2_valid_q;
    logic signed [IW-1:0] s2_s_q;
    logic [TAG_W-1:0]     s2_tag_q;
    logic signed [IW-1:0] s2_s_d;

    logic             out_valid_q;
    logic [W-1:0]     new_q_q;
    logic [TAG_W-1:0] tag_out_q;
    logic             out_sat_q;
    logic [CNT_W-1:0] cnt_q;

    logic [W-1:0] new_q_d;
    logic         sat_d;

    // One shared enable: a stalled output freezes every stage, bubbles included.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    q_gamma_sum #(
        .W(W)
    ) u_gamma_sum (
        .max_q      (bus.max_q),
        .gamma_mask (bus.gamma_mask),
        .g          (g)
    );

    assign old_ext    = {{EXT{bus.old_q[W-1]}}, bus.old_q};
    assign reward_ext = {{EXT{bus.reward[W-1]}}, bus.reward};
    assign d          = reward_ext + g - old_ext;

    assign s2_s_d = s1_old_q + (s1_d_q >>> s1_shift_q);

    always_comb begin
        new_q_d = s2_s_q[W-1:0];
        sat_d   = 1'b0;
`ifdef QUPD_SATURATE_EN
        if (s2_s_q > QMax) begin
            new_q_d = QMax[W-1:0];
            sat_d   = 1'b1;
        end else if (s2_s_q < QMin) begin
            new_q_d = QMin[W-1:0];
            sat_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_d_q      <= '0;
            s1_old_q    <= '0;
            s1_shift_q  <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_s_q      <= '0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            new_q_q     <= '0;
            tag_out_q   <= '0;
            out_sat_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (en) begin
                s1_valid_q  <= bus.in_valid;
                s1_d_q      <= d;
                s1_old_q    <= old_ext;
                s1_shift_q  <= bus.alpha_shift;
                s1_tag_q    <= bus.tag_in;
                s2_valid_q  <= s1_valid_q;
                s2_s_q      <= s2_s_d;
                s2_tag_q    <= s1_tag_q;
                out_valid_q <= s2_valid_q;
                new_q_q     <= new_q_d;
                tag_out_q   <= s2_tag_q;
                out_sat_q   <= sat_d;
            end
            if (out_valid_q && bus.out_ready) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.new_q      = new_q_q;
    assign bus.tag_out    = tag_out_q;
    assign bus.out_sat    = out_sat_q;
    assign bus.update_cnt = cnt_q;

endmodule
